// File: rtl/m_disk_notify_sched_pkg.sv
// -----------------------------------------------------------------------------
// m_disk_notify_sched_pkg
// Shared constants for the virtio disk notify scheduler:
//   - DISK_QUEUE_NUM_MAX : number of virtqueues the disk exposes
//   - QUEUE_STRIDE       : words per virtqueue register group in the disk map
//   - OFS_DESC/AVAIL/USED: word offsets of DescLow, AvailLow, UsedLow in a group
//   - state_e            : scheduler FSM encodings
//   - queue_word_addr()  : byte address of a word inside a queue's group
// -----------------------------------------------------------------------------
`ifndef DISK_QUEUE_NUM_MAX
`define DISK_QUEUE_NUM_MAX 8
`endif

package m_disk_notify_sched_pkg;

   localparam int unsigned DISK_QUEUE_NUM_MAX = `DISK_QUEUE_NUM_MAX;

   localparam logic [31:0] QUEUE_STRIDE = 32'd9;
   localparam logic [31:0] OFS_DESC     = 32'd2;
   localparam logic [31:0] OFS_AVAIL    = 32'd4;
   localparam logic [31:0] OFS_USED     = 32'd6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_F0   = 3'd2,
      ST_F1   = 3'd3,
      ST_F2   = 3'd4,
      ST_F3   = 3'd5,
      ST_OUT  = 3'd6
   } state_e;

   // Byte address of word 'ofs' inside the register group of queue 'idx'.
   function automatic logic [31:0] queue_word_addr(input logic [31:0] idx,
                                                   input logic [31:0] ofs);
      return ((idx * QUEUE_STRIDE) + ofs) << 2;
   endfunction

endpackage

// File: rtl/m_notify_fifo.sv
// -----------------------------------------------------------------------------
// m_notify_fifo
// Small synchronous FIFO holding captured queue notifies.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (clears pointers/count)
//   push, din       : write request and data
//   pop             : remove head entry
//   dout            : head entry (combinational read of the head slot)
//   full, empty     : occupancy flags
//   drop            : push refused this cycle (full and no simultaneous pop)
// A push while full is still accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module m_notify_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign drop  = push && full && !pop;

   // Pointer and occupancy update; a simultaneous push and pop keeps the count.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the empty count hides stale slots.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/m_disk_notify_sched.sv
// -----------------------------------------------------------------------------
// m_disk_notify_sched
// Captures virtio disk queue-notify pulses, fetches DescLow/AvailLow/UsedLow of
// the selected queue through the disk micro-controller port, and hands one
// complete descriptor to the micro-controller over valid/ready.
// Ports:
//   CLK, RST_X                 : clock, synchronous active-low reset
//   i_req, i_qsel, i_qnum      : notify pulse with queue select / QueueNum
//   o_dreq, i_dgnt             : request/grant of the disk port (mode 2)
//   o_daddr, i_ddata           : disk byte address, registered read data
//   o_valid, i_ready           : output handshake
//   o_qsel..o_used             : fetched request fields
//   i_clr, o_ovf, o_bad        : sticky flag clear, overflow, bad-queue flags
//   o_busy                     : work pending or in progress
// -----------------------------------------------------------------------------
module m_disk_notify_sched
   import m_disk_notify_sched_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int QNUM_MAX = `DISK_QUEUE_NUM_MAX
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        i_req,
   input  logic [31:0] i_qsel,
   input  logic [31:0] i_qnum,
   output logic        o_dreq,
   input  logic        i_dgnt,
   output logic [31:0] o_daddr,
   input  logic [31:0] i_ddata,
   output logic        o_valid,
   output logic [31:0] o_qsel,
   output logic [31:0] o_qnum,
   output logic [31:0] o_desc,
   output logic [31:0] o_avail,
   output logic [31:0] o_used,
   input  logic        i_ready,
   input  logic        i_clr,
   output logic        o_ovf,
   output logic        o_bad,
   output logic        o_busy
);

   localparam int          QW         = (QNUM_MAX > 1) ? $clog2(QNUM_MAX) : 1;
   localparam logic [31:0] QNUM_LIMIT = 32'(QNUM_MAX);

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_qsel_q, pend_qsel_d;
   logic [31:0] pend_qnum_q, pend_qnum_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] desc_q, desc_d;
   logic [31:0] avail_q, avail_d;
   logic [31:0] used_q, used_d;
   logic [31:0] oqsel_q, oqsel_d;
   logic [31:0] oqnum_q, oqnum_d;
   logic        ovf_q, ovf_d;
   logic        bad_q, bad_d;

   logic [63:0] fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_drop;
   logic        pop;
   logic        bad_set;
   logic [31:0] head_qsel;
   logic [31:0] head_qnum;
   logic [31:0] head_idx;

   // Notifies pass through one capture stage before entering the FIFO, so a
   // notify sampled at edge N is visible to the idle FSM after edge N+1.
   m_notify_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_X),
      .push  (pend_q),
      .din   ({pend_qsel_q, pend_qnum_q}),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   assign head_qsel = fifo_head[63:32];
   assign head_qnum = fifo_head[31:0];
   assign head_idx  = {{(32-QW){1'b0}}, head_qsel[QW-1:0]};

   // Next-state logic. The head entry stays in the FIFO for the whole fetch
   // and is popped only once the consumer accepts it (or it is rejected).
   always_comb begin
      state_d     = state_q;
      pend_d      = i_req;
      pend_qsel_d = i_qsel;
      pend_qnum_d = i_qnum;
      desc_d      = desc_q;
      avail_d     = avail_q;
      used_d      = used_q;
      oqsel_d     = oqsel_q;
      oqnum_d     = oqnum_q;
      daddr_d     = '0;
      pop         = 1'b0;
      bad_set     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (head_qsel >= QNUM_LIMIT) begin
                  pop     = 1'b1;
                  bad_set = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (i_dgnt) begin
               state_d = ST_F0;
            end
         end
         ST_F0: begin
            state_d = ST_F1;
         end
         ST_F1: begin
            desc_d  = i_ddata;
            state_d = ST_F2;
         end
         ST_F2: begin
            avail_d = i_ddata;
            state_d = ST_F3;
         end
         ST_F3: begin
            used_d  = i_ddata;
            oqsel_d = head_qsel;
            oqnum_d = head_qnum;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (i_ready) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Losing the grant mid-fetch throws away the partial words and waits
      // in REQ (request still asserted) for the next grant.
      if ((state_q inside {ST_F0, ST_F1, ST_F2, ST_F3}) && !i_dgnt) begin
         state_d = ST_REQ;
         desc_d  = '0;
         avail_d = '0;
         used_d  = '0;
      end

      // Address is registered from the next state so it is on the port for
      // the whole F0..F2 cycle; read data returns one cycle later.
      case (state_d)
         ST_F0:   daddr_d = queue_word_addr(head_idx, OFS_DESC);
         ST_F1:   daddr_d = queue_word_addr(head_idx, OFS_AVAIL);
         ST_F2:   daddr_d = queue_word_addr(head_idx, OFS_USED);
         default: daddr_d = '0;
      endcase

      // Sticky flags: a set event in the same cycle as a clear wins.
      ovf_d = fifo_drop ? 1'b1 : (i_clr ? 1'b0 : ovf_q);
      bad_d = bad_set   ? 1'b1 : (i_clr ? 1'b0 : bad_q);
   end

   // All state and output registers, cleared together by reset.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q     <= ST_IDLE;
         pend_q      <= 1'b0;
         pend_qsel_q <= '0;
         pend_qnum_q <= '0;
         daddr_q     <= '0;
         desc_q      <= '0;
         avail_q     <= '0;
         used_q      <= '0;
         oqsel_q     <= '0;
         oqnum_q     <= '0;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_qsel_q <= pend_qsel_d;
         pend_qnum_q <= pend_qnum_d;
         daddr_q     <= daddr_d;
         desc_q      <= desc_d;
         avail_q     <= avail_d;
         used_q      <= used_d;
         oqsel_q     <= oqsel_d;
         oqnum_q     <= oqnum_d;
         ovf_q       <= ovf_d;
         bad_q       <= bad_d;
      end
   end

   // Outputs are pure functions of registers, so inputs never reach them
   // combinationally.
   assign o_dreq  = state_q inside {ST_REQ, ST_F0, ST_F1, ST_F2, ST_F3};
   assign o_valid = (state_q == ST_OUT);
   assign o_daddr = daddr_q;
   assign o_desc  = desc_q;
   assign o_avail = avail_q;
   assign o_used  = used_q;
   assign o_qsel  = oqsel_q;
   assign o_qnum  = oqnum_q;
   assign o_ovf   = ovf_q;
   assign o_bad   = bad_q;
   assign o_busy  = pend_q || !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_m_disk_notify_sched.sv
`timescale 1ns/1ps
module tb_m_disk_notify_sched;

   localparam int QMAX = `DISK_QUEUE_NUM_MAX;

   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_qsel = '0;
   logic [31:0] i_qnum = '0;
   logic        o_dreq;
   logic        i_dgnt = 1'b0;
   logic [31:0] o_daddr;
   logic [31:0] i_ddata = '0;
   logic        o_valid;
   logic [31:0] o_qsel, o_qnum, o_desc, o_avail, o_used;
   logic        i_ready = 1'b0;
   logic        i_clr = 1'b0;
   logic        o_ovf, o_bad, o_busy;

   int          assertCount = 0;
   int          failCount = 0;
   logic [31:0] diskSalt = '0;
   logic [31:0] addrLog [$];

   always #5 CLK = ~CLK;

   m_disk_notify_sched #(
      .DEPTH    (4),
      .QNUM_MAX (QMAX)
   ) dut (
      .CLK     (CLK),
      .RST_X   (RST_X),
      .i_req   (i_req),
      .i_qsel  (i_qsel),
      .i_qnum  (i_qnum),
      .o_dreq  (o_dreq),
      .i_dgnt  (i_dgnt),
      .o_daddr (o_daddr),
      .i_ddata (i_ddata),
      .o_valid (o_valid),
      .o_qsel  (o_qsel),
      .o_qnum  (o_qnum),
      .o_desc  (o_desc),
      .o_avail (o_avail),
      .o_used  (o_used),
      .i_ready (i_ready),
      .i_clr   (i_clr),
      .o_ovf   (o_ovf),
      .o_bad   (o_bad),
      .o_busy  (o_busy)
   );

   // Disk word contents: 0x1000 * (slot within group / 2) + 0x10000 * group.
   function automatic logic [31:0] diskWord(input logic [31:0] addr);
      logic [31:0] w;
      w = addr >> 2;
      return 32'h1000 * ((w % 9) / 2) + 32'h10000 * (w / 9) + diskSalt;
   endfunction

   // Registered disk read port: data for an address appears one cycle later.
   always @(posedge CLK) begin
      i_ddata <= diskWord(o_daddr);
   end

   // Record every non-zero address the scheduler presents.
   always @(negedge CLK) begin
      if (o_daddr != 32'h0) begin
         addrLog.push_back(o_daddr);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] q, input logic [31:0] n);
      @(negedge CLK);
      i_req  = 1'b1;
      i_qsel = q;
      i_qnum = n;
      @(negedge CLK);
      i_req  = 1'b0;
   endtask

   task automatic waitValid(input int budget);
      int k;
      k = 0;
      while (!o_valid && k < budget) begin
         @(negedge CLK);
         k++;
      end
      checkOutput("validReached", 32'(o_valid), 32'd1);
   endtask

   task automatic waitAddr(input logic [31:0] addr, input int budget);
      int k;
      k = 0;
      while (o_daddr !== addr && k < budget) begin
         @(negedge CLK);
         k++;
      end
      checkOutput("addrReached", o_daddr, addr);
   endtask

   task automatic acceptOutput();
      @(negedge CLK);
      i_ready = 1'b1;
      @(negedge CLK);
      i_ready = 1'b0;
      checkOutput("validDropped", 32'(o_valid), 32'd0);
   endtask

   task automatic checkFetch(input logic [31:0] q, input logic [31:0] n);
      checkOutput("qsel",  o_qsel,  q);
      checkOutput("qnum",  o_qnum,  n);
      checkOutput("desc",  o_desc,  32'h1000 + 32'h10000 * q + diskSalt);
      checkOutput("avail", o_avail, 32'h2000 + 32'h10000 * q + diskSalt);
      checkOutput("used",  o_used,  32'h3000 + 32'h10000 * q + diskSalt);
   endtask

   task automatic checkAddrs(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2);
      checkOutput("addrCount", 32'(addrLog.size()), 32'd3);
      if (addrLog.size() >= 3) begin
         checkOutput("addrDesc",  addrLog[0], a0);
         checkOutput("addrAvail", addrLog[1], a1);
         checkOutput("addrUsed",  addrLog[2], a2);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dreq"},  32'(o_dreq),  32'd0);
      checkOutput({tag, "_daddr"}, o_daddr,      32'd0);
      checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
      checkOutput({tag, "_qsel"},  o_qsel,       32'd0);
      checkOutput({tag, "_qnum"},  o_qnum,       32'd0);
      checkOutput({tag, "_desc"},  o_desc,       32'd0);
      checkOutput({tag, "_avail"}, o_avail,      32'd0);
      checkOutput({tag, "_used"},  o_used,       32'd0);
      checkOutput({tag, "_ovf"},   32'(o_ovf),   32'd0);
      checkOutput({tag, "_bad"},   32'(o_bad),   32'd0);
      checkOutput({tag, "_busy"},  32'(o_busy),  32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge CLK);
      checkAllZero("reset");
      RST_X  = 1'b1;
      i_dgnt = 1'b1;

      // Single notify, latency and addresses
      $display("[TB] single notify qsel=0");
      addrLog.delete();
      applyStimulus(32'd0, 32'd8);
      repeat (2) @(negedge CLK);
      checkOutput("reqAtN2", 32'(o_dreq), 32'd1);
      repeat (4) @(negedge CLK);
      checkOutput("validAtN6", 32'(o_valid), 32'd0);
      @(negedge CLK);
      checkOutput("validAtN7", 32'(o_valid), 32'd1);
      checkOutput("dreqInOut", 32'(o_dreq), 32'd0);
      checkFetch(32'd0, 32'd8);
      checkAddrs(32'h08, 32'h10, 32'h18);
      acceptOutput();
      checkOutput("idleBusy", 32'(o_busy), 32'd0);

      // qsel=1 with consumer stall
      $display("[TB] qsel=1 with stall");
      addrLog.delete();
      applyStimulus(32'd1, 32'd16);
      waitValid(20);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("stallValid", 32'(o_valid), 32'd1);
         checkOutput("stallDesc", o_desc, 32'h11000);
      end
      checkFetch(32'd1, 32'd16);
      checkAddrs(32'h2C, 32'h34, 32'h3C);
      acceptOutput();

      // Overflow: five notifies into a four-deep FIFO
      $display("[TB] overflow");
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         i_req  = 1'b1;
         i_qsel = 32'(k);
         i_qnum = 32'(100 + k);
      end
      @(negedge CLK);
      i_req = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("ovfSet", 32'(o_ovf), 32'd1);
      for (int k = 0; k < 4; k++) begin
         waitValid(40);
         checkFetch(32'(k), 32'(100 + k));
         acceptOutput();
      end
      repeat (3) @(negedge CLK);
      checkOutput("ovfNoFifth", 32'(o_valid), 32'd0);
      checkOutput("ovfBusy", 32'(o_busy), 32'd0);
      @(negedge CLK);
      i_clr = 1'b1;
      @(negedge CLK);
      i_clr = 1'b0;
      checkOutput("ovfCleared", 32'(o_ovf), 32'd0);

      // Out-of-range queue select
      $display("[TB] bad qsel");
      applyStimulus(32'(QMAX), 32'd4);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         checkOutput("badNoReq", 32'(o_dreq), 32'd0);
      end
      checkOutput("badSet", 32'(o_bad), 32'd1);
      checkOutput("badBusy", 32'(o_busy), 32'd0);
      repeat (4) @(negedge CLK);
      checkOutput("badNoReqLate", 32'(o_dreq), 32'd0);
      checkOutput("badNoValid", 32'(o_valid), 32'd0);
      @(negedge CLK);
      i_clr = 1'b1;
      @(negedge CLK);
      i_clr = 1'b0;
      checkOutput("badCleared", 32'(o_bad), 32'd0);

      // Grant lost in F2, restart after regrant
      $display("[TB] grant drop in F2");
      applyStimulus(32'd2, 32'd32);
      waitAddr(32'h60, 20);
      i_dgnt   = 1'b0;
      diskSalt = 32'h0050_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checkOutput("abortReq", 32'(o_dreq), 32'd1);
         checkOutput("abortNoValid", 32'(o_valid), 32'd0);
      end
      addrLog.delete();
      i_dgnt = 1'b1;
      waitValid(20);
      checkFetch(32'd2, 32'd32);
      checkAddrs(32'h50, 32'h58, 32'h60);
      acceptOutput();
      diskSalt = 32'h0;

      // Reset taken during F1
      $display("[TB] reset mid-fetch");
      applyStimulus(32'd3, 32'd48);
      waitAddr(32'h7C, 20);
      RST_X = 1'b0;
      @(negedge CLK);
      checkAllZero("midReset");
      RST_X = 1'b1;
      applyStimulus(32'd3, 32'd48);
      waitValid(20);
      checkFetch(32'd3, 32'd48);
      acceptOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/m_disk_notify_sched.md
# m_disk_notify_sched

Sits directly downstream of the virtio disk register block. Captures queue-notify pulses (notify request, queue select, queue size) into a small FIFO. For each entry it takes the disk's micro-controller access port and reads the selected queue's DescLow, AvailLow and UsedLow words. It then presents one complete request descriptor to the disk micro-controller over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, notify FIFO entries (power of two, ≥2)
- QNUM_MAX, `DISK_QUEUE_NUM_MAX, number of virtqueues; selects at or above this value are rejected

Ports:
- CLK  in  1  clock; everything is on posedge
- RST_X  in  1  reset; one clock, synchronous, active-low
- i_req  in  1  notify pulse from the disk block (CPU write to offset 0x50)
- i_qsel  in  32  queue select accompanying i_req
- i_qnum  in  32  QueueNum accompanying i_req
- o_dreq  out  1  request to own the disk micro-controller port (mode 2)
- i_dgnt  in  1  grant; disk is in mode 2 while high
- o_daddr  out  32  byte address driven to the disk in mode 2
- i_ddata  in  32  disk read data; registered, valid one cycle after o_daddr
- o_valid  out  1  fetched request available
- o_qsel, o_qnum, o_desc, o_avail, o_used  out  32 each  fetched fields, stable while o_valid
- i_ready  in  1  consumer accepts; transfer when o_valid && i_ready
- i_clr  in  1  clears sticky flags
- o_ovf  out  1  sticky: a notify was dropped because the FIFO was full
- o_bad  out  1  sticky: a notify with qsel ≥ QNUM_MAX was discarded
- o_busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Push: each i_req cycle writes {i_qsel, i_qnum} into the FIFO.
  - When the FIFO is full, the push is dropped and o_ovf is set.
  - Exception: full with a pop in the same cycle accepts the push.
- No coalescing. Each notify yields exactly one fetch and one output transfer.
- FSM states: IDLE, REQ, F0, F1, F2, F3, OUT.
- IDLE, FIFO non-empty, head qsel ≥ QNUM_MAX: pop the head, set o_bad, stay IDLE.
- IDLE, FIFO non-empty, head valid: go to REQ and assert o_dreq.
- REQ: hold o_dreq. On i_dgnt go to F0.
- F0: o_daddr = (qsel*9+2)<<2 (DescLow).
- F1: o_daddr = (qsel*9+4)<<2 (AvailLow). Capture i_ddata into o_desc.
- F2: o_daddr = (qsel*9+6)<<2 (UsedLow). Capture i_ddata into o_avail.
- F3: capture i_ddata into o_used. Deassert o_dreq at the F3→OUT edge. Latch o_qsel/o_qnum from the FIFO head. Go to OUT.
- OUT: o_valid high. On i_ready: pop the FIFO, drop o_valid, go to IDLE.
- Address arithmetic is 32-bit; qsel*9 is computed from the low $clog2(QNUM_MAX) bits.
- o_daddr is 0 outside F0–F2.
- i_dgnt falling during F0–F3: abort, discard partial captures, return to REQ (o_dreq stays high), restart at F0 on the next grant.
- i_clr clears o_ovf and o_bad. If a set event occurs in the same cycle, the set wins.

## Timing
- All outputs reset to 0: o_dreq, o_daddr, o_valid, all data outputs, o_ovf, o_bad, o_busy.
- Reset clears the FIFO and returns the FSM to IDLE at the same edge, including a reset taken mid-fetch or in OUT.
- Latency, with grant present in the REQ cycle and the entry pushed at edge N:
  - IDLE at N+1, REQ at N+2, F0–F3 at N+3…N+6.
  - o_valid high from edge N+7.
- Back-to-back: after the OUT→IDLE edge, the next entry enters REQ one cycle later. Throughput is 1 request per 7 cycles plus consumer stall.
- o_dreq is low in IDLE and OUT, high in REQ and F0–F3.
- Outputs are registered; there is no combinational path from i_ready or i_dgnt to any output.
- A push and a pop in the same cycle leave the count unchanged.

## Structure
- Shared package/define.vh holds:
  - `DISK_QUEUE_NUM_MAX
  - queue stride 9
  - word offsets DESC=2, AVAIL=4, USED=6
  - FSM state encodings
- Natural sub-module: m_notify_fifo (DEPTH × 64-bit, push/pop/full/empty, full-with-pop accepts push).
- FSM, address generation and capture registers stay in the top.

## Test plan
- Single notify: i_req with qsel=0, qnum=8; disk model returns 0x1000/0x2000/0x3000; grant immediate → o_valid at N+7 with desc=0x1000, avail=0x2000, used=0x3000, qnum=8; addresses seen are 0x08, 0x10, 0x18.
- qsel=1 → addresses 0x2C, 0x34, 0x3C; i_ready held low 5 cycles → outputs stable until accepted.
- Five notifies back-to-back with i_ready=0, DEPTH=4 → four entries retained, o_ovf=1. Raise i_ready → four transfers in push order. i_clr → o_ovf=0.
- qsel=QNUM_MAX → no o_dreq, o_bad=1, o_busy returns to 0 within 2 cycles.
- i_dgnt dropped in F2 → restart from F0 after regrant, values from the second pass only.
- Assert RST_X low in F1 → next cycle all outputs 0, FIFO empty; a fresh notify then completes normally.
